// File: rtl/chirp_pkg.sv
// Shared definitions for the streaming chirp generator: register map, FSM states,
// MODE field layout and the spreading-factor clamp.
package chirp_pkg;

  localparam logic [1:0] ADDR_SF     = 2'd0;
  localparam logic [1:0] ADDR_SYMBOL = 2'd1;
  localparam logic [1:0] ADDR_MODE   = 2'd2;
  localparam logic [1:0] ADDR_REPEAT = 2'd3;

  localparam int MODE_DOWN_BIT = 0;
  localparam int MODE_OSR_LSB  = 1;
  localparam int MODE_OSR_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } chirp_state_e;

  function automatic int unsigned clamp_sf(input int unsigned v, input int unsigned lo,
                                           input int unsigned hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/chirp_sine_lut.sv
// Combinational quarter-wave sine ROM: folds the LUT_ADDR+2 phase MSBs into one quadrant,
// looks up the magnitude and applies the sign.
module chirp_sine_lut #(
  parameter int DATA_WIDTH = 8,
  parameter int LUT_ADDR   = 6
) (
  input  logic [LUT_ADDR+1:0]          phase_i,
  output logic signed [DATA_WIDTH-1:0] sample_o
);

  localparam int     QSIZE = 1 << LUT_ADDR;
  localparam int     AMP   = (1 << (DATA_WIDTH - 1)) - 1;
  localparam longint ONE   = 64'sd1 << 30;
  localparam longint PI_S  = 64'sd3373259426;

  // round(AMP * sin(pi/2 * idx / QSIZE)) via a fixed-point Taylor series, so the table
  // follows DATA_WIDTH/LUT_ADDR without any real arithmetic.
  function automatic int quarter_sine(input int idx);
    longint x, term, sum;
    x    = (PI_S * longint'(idx)) / longint'(2 * QSIZE);
    term = x;
    sum  = x;
    for (int n = 1; n <= 8; n++) begin
      term = -((((term * x) / ONE) * x) / ONE) / longint'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    return int'((sum * longint'(AMP) + ONE / 2) / ONE);
  endfunction

  logic [DATA_WIDTH-2:0] rom [QSIZE];

  for (genvar gi = 0; gi < QSIZE; gi++) begin : g_rom
    localparam int ENTRY = quarter_sine(gi);
    assign rom[gi] = (DATA_WIDTH-1)'(ENTRY);
  end

  logic [1:0]            quad;
  logic [LUT_ADDR-1:0]   addr;
  logic [LUT_ADDR-1:0]   addr_mir;
  logic [DATA_WIDTH-2:0] mag;

  assign quad     = phase_i[LUT_ADDR+1:LUT_ADDR];
  assign addr     = phase_i[LUT_ADDR-1:0];
  assign addr_mir = ~addr + LUT_ADDR'(1);

  // Mirrored quadrants at offset 0 land on the peak, which sits one past the table end.
  always_comb begin
    mag = rom[addr];
    if (quad[0]) begin
      mag = (addr == '0) ? (DATA_WIDTH-1)'(AMP) : rom[addr_mir];
    end
    sample_o = quad[1] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  end

endmodule

// File: rtl/chirp_gen_stream.sv
// Register-configured up/down chirp source on a valid/ready stream with cyclic shift,
// oversampling and multi-symbol frames. Define CHIRP_IQ_EN to add the cosine output o_data_q.
module chirp_gen_stream
  import chirp_pkg::*;
#(
  parameter int PHASE_WIDTH = 32,
  parameter int MAX_SF      = 8,
  parameter int MIN_SF      = 5,
  parameter int DATA_WIDTH  = 8,
  parameter int LUT_ADDR    = 6
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_cfg_we,
  input  logic [1:0]                   i_cfg_addr,
  input  logic [MAX_SF-1:0]            i_cfg_wdata,
  input  logic                         i_start,
  output logic                         o_busy,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic signed [DATA_WIDTH-1:0] o_data,
  output logic                         o_last,
  output logic                         o_done_n
`ifdef CHIRP_IQ_EN
  ,
  output logic signed [DATA_WIDTH-1:0] o_data_q
`endif
);

  localparam int SF_W  = $clog2(MAX_SF + 1);
  localparam int OSR_W = (1 << MODE_OSR_W) - 1;
  localparam int IDX_W = LUT_ADDR + 2;

  chirp_state_e state_q, state_d;

  logic [SF_W-1:0]       sf_q, sf_d;
  logic [MAX_SF-1:0]     symbol_q, symbol_d;
  logic [3:0]            mode_q, mode_d;
  logic [MAX_SF-1:0]     repeat_q, repeat_d;

  logic [SF_W-1:0]       sh_sf_q, sh_sf_d;
  logic [MAX_SF-1:0]     sh_symbol_q, sh_symbol_d;
  logic                  sh_down_q, sh_down_d;
  logic [MODE_OSR_W-1:0] sh_osr_q, sh_osr_d;
  logic [MAX_SF-1:0]     sh_repeat_q, sh_repeat_d;

  logic [PHASE_WIDTH-1:0] phase_q, phase_d;
  logic [MAX_SF-1:0]      k_q, k_d;
  logic [OSR_W-1:0]       s_q, s_d;
  logic [MAX_SF-1:0]      sym_cnt_q, sym_cnt_d;
  logic signed [DATA_WIDTH-1:0] data_i_q, data_i_d;
  logic                   last_q, last_d;

  logic                   xfer, load_sample;
  logic [MAX_SF-1:0]      n_mask, fi, k_nx;
  logic [OSR_W-1:0]       osr_mask, s_nx;
  logic                   k_wrap, s_wrap, final_xfer;
  logic [PHASE_WIDTH-1:0] half, freq;
  logic [7:0]             shamt;
  logic [IDX_W-1:0]       lut_idx_i;
  logic signed [DATA_WIDTH-1:0] lut_out_i;

  always_comb begin
    state_d     = state_q;
    sf_d        = sf_q;
    symbol_d    = symbol_q;
    mode_d      = mode_q;
    repeat_d    = repeat_q;
    sh_sf_d     = sh_sf_q;
    sh_symbol_d = sh_symbol_q;
    sh_down_d   = sh_down_q;
    sh_osr_d    = sh_osr_q;
    sh_repeat_d = sh_repeat_q;
    phase_d     = phase_q;
    k_d         = k_q;
    s_d         = s_q;
    sym_cnt_d   = sym_cnt_q;
    last_d      = last_q;
    load_sample = 1'b0;

    xfer     = (state_q == ST_RUN) && i_ready;
    n_mask   = ~({MAX_SF{1'b1}} << sh_sf_q);
    osr_mask = ~({OSR_W{1'b1}} << sh_osr_q);
    k_wrap   = (k_q == n_mask);
    s_wrap   = (s_q == osr_mask);
    s_nx     = s_wrap ? '0 : s_q + 1'b1;
    k_nx     = s_wrap ? (k_wrap ? '0 : k_q + 1'b1) : k_q;
    final_xfer = xfer && s_wrap && k_wrap && (sym_cnt_q == sh_repeat_q);

    // Bin offset fi - N/2 scaled so one symbol of N*OSR samples sweeps the full band.
    fi    = (sh_down_q ? sh_symbol_q - k_q : sh_symbol_q + k_q) & n_mask;
    half  = PHASE_WIDTH'(1) << (sh_sf_q - 1'b1);
    shamt = 8'(PHASE_WIDTH) - 8'(sh_sf_q) - 8'(sh_osr_q);
    freq  = (PHASE_WIDTH'(fi) - half) << shamt;

    unique case (state_q)
      ST_IDLE: begin
        if (i_cfg_we) begin
          unique case (i_cfg_addr)
            ADDR_SF:     sf_d = SF_W'(clamp_sf(32'(i_cfg_wdata), MIN_SF, MAX_SF));
            ADDR_SYMBOL: symbol_d = i_cfg_wdata;
            ADDR_MODE:   mode_d = i_cfg_wdata[3:0];
            ADDR_REPEAT: repeat_d = i_cfg_wdata;
            default: ;
          endcase
        end
        if (i_start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        sh_sf_d     = sf_q;
        sh_symbol_d = symbol_q;
        sh_down_d   = mode_q[MODE_DOWN_BIT];
        sh_osr_d    = mode_q[MODE_OSR_LSB +: MODE_OSR_W];
        sh_repeat_d = repeat_q;
        phase_d     = '0;
        k_d         = '0;
        s_d         = '0;
        sym_cnt_d   = '0;
        last_d      = 1'b0;
        load_sample = 1'b1;
        state_d     = ST_RUN;
      end
      ST_RUN: begin
        if (xfer) begin
          phase_d     = phase_q + freq;
          s_d         = s_nx;
          k_d         = k_nx;
          last_d      = (k_nx == n_mask) && (s_nx == osr_mask);
          load_sample = 1'b1;
          if (s_wrap && k_wrap) sym_cnt_d = sym_cnt_q + 1'b1;
          if (final_xfer) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The next sample is looked up from the next phase so it is ready in the transfer cycle.
  assign lut_idx_i = phase_d[PHASE_WIDTH-1 -: IDX_W];
  assign data_i_d  = load_sample ? lut_out_i : data_i_q;

  chirp_sine_lut #(
    .DATA_WIDTH (DATA_WIDTH),
    .LUT_ADDR   (LUT_ADDR)
  ) u_lut_i (
    .phase_i  (lut_idx_i),
    .sample_o (lut_out_i)
  );

`ifdef CHIRP_IQ_EN
  logic [IDX_W-1:0]             lut_idx_q;
  logic signed [DATA_WIDTH-1:0] lut_out_q;
  logic signed [DATA_WIDTH-1:0] data_q_q, data_q_d;

  assign lut_idx_q = lut_idx_i + IDX_W'(1 << LUT_ADDR);
  assign data_q_d  = load_sample ? lut_out_q : data_q_q;

  chirp_sine_lut #(
    .DATA_WIDTH (DATA_WIDTH),
    .LUT_ADDR   (LUT_ADDR)
  ) u_lut_q (
    .phase_i  (lut_idx_q),
    .sample_o (lut_out_q)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) data_q_q <= '0;
    else          data_q_q <= data_q_d;
  end

  assign o_data_q = data_q_q;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      sf_q        <= SF_W'(MIN_SF);
      symbol_q    <= '0;
      mode_q      <= '0;
      repeat_q    <= '0;
      sh_sf_q     <= SF_W'(MIN_SF);
      sh_symbol_q <= '0;
      sh_down_q   <= 1'b0;
      sh_osr_q    <= '0;
      sh_repeat_q <= '0;
      phase_q     <= '0;
      k_q         <= '0;
      s_q         <= '0;
      sym_cnt_q   <= '0;
      data_i_q    <= '0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sf_q        <= sf_d;
      symbol_q    <= symbol_d;
      mode_q      <= mode_d;
      repeat_q    <= repeat_d;
      sh_sf_q     <= sh_sf_d;
      sh_symbol_q <= sh_symbol_d;
      sh_down_q   <= sh_down_d;
      sh_osr_q    <= sh_osr_d;
      sh_repeat_q <= sh_repeat_d;
      phase_q     <= phase_d;
      k_q         <= k_d;
      s_q         <= s_d;
      sym_cnt_q   <= sym_cnt_d;
      data_i_q    <= data_i_d;
      last_q      <= last_d;
    end
  end

  assign o_busy   = (state_q != ST_IDLE);
  assign o_valid  = (state_q == ST_RUN);
  assign o_done_n = (state_q != ST_DONE);
  assign o_data   = data_i_q;
  assign o_last   = last_q;

endmodule
